multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter MEM_HANDSHAKE, default 1: 1 = memory states hold until mem_ready_i; 0 = memory assumed ready every cycle.
REQ-002 Parameter ILLEGAL_HALT, default 1: 1 = unknown opcode halts in ILLEGAL; 0 = skip back to FETCH.
REQ-003 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-004 clk_i  in  1  clock; all state changes on the rising edge.
REQ-005 rst_n_i  in  1  reset; asynchronous, active-low.
REQ-006 opcode_i  in  7  opcode of the instruction register; funct_3_i  in  3  funct3 of the instruction register.
REQ-007 mem_ready_i  in  1  memory access completes this cycle.
REQ-008 pc_wr_en_o  out  1  PC load; adr_src_o  out  1  memory address select (0 = PC, 1 = ALUOut); ir_wr_en_o  out  1  instruction/old-PC register load.
REQ-009 mem_rd_en_o  out  1  memory read request; mem_wr_en_o  out  1  memory write request; reg_wr_en_o  out  1  register file write.
REQ-010 imm_src_o  out  3  immediate format (000 I, 001 S, 010 B, 011 U, 100 J, 101 shamt).
REQ-011 alu_src_a_o  out  2  (00 PC, 01 oldPC, 10 rs1); alu_src_b_o  out  2  (00 rs2, 01 imm, 10 constant 4).
REQ-012 result_src_o  out  2  (00 ALUOut, 01 read data, 10 ALU result); alu_op_o  out  2  (00 add, 01 branch compare, 10 funct-decoded, 11 pass B).
REQ-013 branch_o  out  1  conditional PC update; illegal_instr_o  out  1  in ILLEGAL state.
REQ-014 retire_o  out  1  one-cycle pulse per completed instruction; instr_count_o  out  CNT_W  retired count; state_o  out  4  current state encoding.

Function
REQ-015 States: FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I, ALU_WB, BRANCH, JAL, JALR, JALR_LINK, LUI, AUIPC, ILLEGAL.
REQ-016 Outputs are Moore functions of state (imm_src_o also of registered opcode_i/funct_3_i); every enable and field not listed for a state is 0.
REQ-017 "ready" means mem_ready_i=1, or always true when MEM_HANDSHAKE=0.
REQ-018 FETCH: mem_rd_en=1, adr_src=0, src_a=00, src_b=10, alu_op=00, result_src=10; ir_wr_en=pc_wr_en=1 only when ready; -> DECODE when ready, else hold.
REQ-019 DECODE: src_a=01, src_b=01, alu_op=00, imm_src=100 if opcode JAL else 010; next by opcode: 0000011/0100011 -> MEM_ADR, 0110011 -> EXEC_R, 0010011 -> EXEC_I, 1100011 -> BRANCH, 1101111 -> JAL, 1100111 -> JALR, 0110111 -> LUI, 0010111 -> AUIPC, other -> ILLEGAL.
REQ-020 MEM_ADR: src_a=10, src_b=01, alu_op=00, imm_src 000 (load) / 001 (store); -> MEM_READ (load) or MEM_WRITE (store).
REQ-021 MEM_READ: adr_src=1, mem_rd_en=1; -> MEM_WB when ready, else hold. MEM_WB: result_src=01, reg_wr_en=1; -> FETCH, retire.
REQ-022 MEM_WRITE: adr_src=1, mem_wr_en=1; hold until ready; then -> FETCH, retire.
REQ-023 EXEC_R: src_a=10, src_b=00, alu_op=10 -> ALU_WB. EXEC_I: src_a=10, src_b=01, alu_op=10, imm_src=101 if funct3 001/101 else 000 -> ALU_WB.
REQ-024 ALU_WB: result_src=00, reg_wr_en=1; -> FETCH, retire.
REQ-025 BRANCH: src_a=10, src_b=00, alu_op=01, result_src=00, branch_o=1; -> FETCH, retire.
REQ-026 JAL: src_a=01, src_b=10, alu_op=00, result_src=00, pc_wr_en=1 -> ALU_WB.
REQ-027 JALR: src_a=10, src_b=01, imm_src=000, alu_op=00, result_src=10, pc_wr_en=1 -> JALR_LINK; JALR_LINK: src_a=01, src_b=10, alu_op=00 -> ALU_WB.
REQ-028 LUI: src_b=01, imm_src=011, alu_op=11 -> ALU_WB. AUIPC: src_a=01, src_b=01, imm_src=011, alu_op=00 -> ALU_WB.
REQ-029 ILLEGAL: illegal_instr_o=1, no retire; ILLEGAL_HALT=1 holds until reset; ILLEGAL_HALT=0 -> FETCH next cycle.
REQ-030 retire_o is asserted combinationally in the cycle the retiring transition is taken; instr_count_o increments by 1 on that edge, wrapping modulo 2^CNT_W.
REQ-031 Minimum latency with ready always 1: loads 5 cycles, stores/R/I/LUI/AUIPC/JAL 4, branches 3, JALR 5.

Reset
REQ-032 While rst_n_i=0: state=FETCH, instr_count_o=0, all registered state cleared immediately, regardless of clock; an in-flight access is abandoned.
REQ-033 First rising edge after release evaluates FETCH normally.

Verification
REQ-034 ready=1, opcode 0110011 -> FETCH,DECODE,EXEC_R,ALU_WB,FETCH; retire_o pulse in ALU_WB; count 0->1.
REQ-035 load with mem_ready_i low 3 cycles in MEM_READ -> MEM_READ held 4 cycles, mem_rd_en_o=1, adr_src_o=1 throughout; reg_wr_en_o=1 only in MEM_WB.
REQ-036 opcode 0010011 funct3 101 -> imm_src_o=101 in EXEC_I; funct3 000 -> 000.
REQ-037 opcode 1111111, ILLEGAL_HALT=1 -> ILLEGAL held, illegal_instr_o=1, count unchanged; ILLEGAL_HALT=0 -> FETCH next cycle.
REQ-038 CNT_W=4, count 15, retire -> 0; rst_n_i low mid-MEM_WRITE -> state FETCH, mem_wr_en_o=0 without a clock edge.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing a multicycle RV32I datapath, with retired-instruction counter
module multicycle_control_unit #(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter bit ILLEGAL_HALT  = 1'b1,
   parameter int CNT_W         = 32
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [6:0]       opcode_i,
   input  logic [2:0]       funct_3_i,
   input  logic             mem_ready_i,
   output logic             pc_wr_en_o,
   output logic             adr_src_o,
   output logic             ir_wr_en_o,
   output logic             mem_rd_en_o,
   output logic             mem_wr_en_o,
   output logic             reg_wr_en_o,
   output logic [2:0]       imm_src_o,
   output logic [1:0]       alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [1:0]       result_src_o,
   output logic [1:0]       alu_op_o,
   output logic             branch_o,
   output logic             illegal_instr_o,
   output logic             retire_o,
   output logic [CNT_W-1:0] instr_count_o,
   output logic [3:0]       state_o
);
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   typedef enum logic [3:0] {
      FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I,
      ALU_WB, BRANCH, JAL, JALR, JALR_LINK, LUI, AUIPC, ILLEGAL
   } state_t;
   state_t state, next;
   logic ready, is_store, is_shift;
   assign ready    = mem_ready_i || !MEM_HANDSHAKE;
   assign is_store = opcode_i == OP_STORE;
   assign is_shift = funct_3_i == 3'b001 || funct_3_i == 3'b101;
   assign state_o  = state;
   assign retire_o = state == MEM_WB || state == ALU_WB || state == BRANCH || (state == MEM_WRITE && ready);
   // next-state selection; memory states wait on ready, DECODE dispatches on opcode
   always_comb begin
      next = state;
      case (state)
         FETCH:     next = ready ? DECODE : FETCH;
         DECODE:
            case (opcode_i)
               OP_LOAD, OP_STORE: next = MEM_ADR;
               OP_R:              next = EXEC_R;
               OP_I:              next = EXEC_I;
               OP_BR:             next = BRANCH;
               OP_JAL:            next = JAL;
               OP_JALR:           next = JALR;
               OP_LUI:            next = LUI;
               OP_AUIPC:          next = AUIPC;
               default:           next = ILLEGAL;
            endcase
         MEM_ADR:   next = is_store ? MEM_WRITE : MEM_READ;
         MEM_READ:  next = ready ? MEM_WB : MEM_READ;
         MEM_WRITE: next = ready ? FETCH : MEM_WRITE;
         EXEC_R, EXEC_I, JAL, JALR_LINK, LUI, AUIPC: next = ALU_WB;
         JALR:      next = JALR_LINK;
         MEM_WB, ALU_WB, BRANCH: next = FETCH;
         ILLEGAL:   next = ILLEGAL_HALT ? ILLEGAL : FETCH;
         default:   next = FETCH;
      endcase
   end
   // datapath controls decoded from the current state; unlisted fields stay 0
   always_comb begin
      pc_wr_en_o      = 1'b0;
      adr_src_o       = 1'b0;
      ir_wr_en_o      = 1'b0;
      mem_rd_en_o     = 1'b0;
      mem_wr_en_o     = 1'b0;
      reg_wr_en_o     = 1'b0;
      imm_src_o       = 3'b000;
      alu_src_a_o     = 2'b00;
      alu_src_b_o     = 2'b00;
      result_src_o    = 2'b00;
      alu_op_o        = 2'b00;
      branch_o        = 1'b0;
      illegal_instr_o = 1'b0;
      case (state)
         FETCH: begin
            mem_rd_en_o  = 1'b1;
            alu_src_b_o  = 2'b10;
            result_src_o = 2'b10;
            ir_wr_en_o   = ready;
            pc_wr_en_o   = ready;
         end
         DECODE: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b01;
            imm_src_o   = opcode_i == OP_JAL ? 3'b100 : 3'b010;
         end
         MEM_ADR: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b01;
            imm_src_o   = is_store ? 3'b001 : 3'b000;
         end
         MEM_READ: begin
            adr_src_o   = 1'b1;
            mem_rd_en_o = 1'b1;
         end
         MEM_WB: begin
            result_src_o = 2'b01;
            reg_wr_en_o  = 1'b1;
         end
         MEM_WRITE: begin
            adr_src_o   = 1'b1;
            mem_wr_en_o = 1'b1;
         end
         EXEC_R: begin
            alu_src_a_o = 2'b10;
            alu_op_o    = 2'b10;
         end
         EXEC_I: begin
            alu_src_a_o = 2'b10;
            alu_src_b_o = 2'b01;
            alu_op_o    = 2'b10;
            imm_src_o   = is_shift ? 3'b101 : 3'b000;
         end
         ALU_WB: reg_wr_en_o = 1'b1;
         BRANCH: begin
            alu_src_a_o = 2'b10;
            alu_op_o    = 2'b01;
            branch_o    = 1'b1;
         end
         JAL: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b10;
            pc_wr_en_o  = 1'b1;
         end
         JALR: begin
            alu_src_a_o  = 2'b10;
            alu_src_b_o  = 2'b01;
            result_src_o = 2'b10;
            pc_wr_en_o   = 1'b1;
         end
         JALR_LINK: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b10;
         end
         LUI: begin
            alu_src_b_o = 2'b01;
            imm_src_o   = 3'b011;
            alu_op_o    = 2'b11;
         end
         AUIPC: begin
            alu_src_a_o = 2'b01;
            alu_src_b_o = 2'b01;
            imm_src_o   = 3'b011;
         end
         ILLEGAL: illegal_instr_o = 1'b1;
         default: ;
      endcase
   end
   // state and retired-instruction counter; reset abandons any in-flight access
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state         <= FETCH;
         instr_count_o <= '0;
      end else begin
         state <= next;
         if (retire_o) instr_count_o <= instr_count_o + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench driving directed instruction sequences through two configurations
module tb_multicycle_control_unit;
   localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADR = 4'd2, S_MEM_READ = 4'd3,
                          S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXEC_R = 4'd6, S_EXEC_I = 4'd7,
                          S_ALU_WB = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_JALR = 4'd11,
                          S_JALR_LINK = 4'd12, S_LUI = 4'd13, S_AUIPC = 4'd14, S_ILLEGAL = 4'd15;
   localparam logic [18:0] C_F   = {6'b101100, 3'b000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
   localparam logic [18:0] C_FW  = {6'b000100, 3'b000, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00};
   localparam logic [18:0] C_DB  = {6'b000000, 3'b010, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
   localparam logic [18:0] C_DJ  = {6'b000000, 3'b100, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
   localparam logic [18:0] C_AL  = {6'b000000, 3'b000, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
   localparam logic [18:0] C_AS  = {6'b000000, 3'b001, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
   localparam logic [18:0] C_RD  = {6'b010100, 13'b0};
   localparam logic [18:0] C_MWB = {6'b000001, 3'b000, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
   localparam logic [18:0] C_WR  = {6'b010010, 13'b0};
   localparam logic [18:0] C_XR  = {6'b000000, 3'b000, 2'b10, 2'b00, 2'b00, 2'b10, 2'b00};
   localparam logic [18:0] C_XS  = {6'b000000, 3'b101, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00};
   localparam logic [18:0] C_XI  = {6'b000000, 3'b000, 2'b10, 2'b01, 2'b00, 2'b10, 2'b00};
   localparam logic [18:0] C_AW  = {6'b000001, 13'b0};
   localparam logic [18:0] C_BR  = {6'b000000, 3'b000, 2'b10, 2'b00, 2'b00, 2'b01, 2'b10};
   localparam logic [18:0] C_JL  = {6'b100000, 3'b000, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
   localparam logic [18:0] C_JR  = {6'b100000, 3'b000, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00};
   localparam logic [18:0] C_LK  = {6'b000000, 3'b000, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
   localparam logic [18:0] C_LU  = {6'b000000, 3'b011, 2'b00, 2'b01, 2'b00, 2'b11, 2'b00};
   localparam logic [18:0] C_AU  = {6'b000000, 3'b011, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
   localparam logic [18:0] C_IL  = {6'b000000, 13'b1};
   typedef struct packed {
      logic        id;
      logic [3:0]  st;
      logic [18:0] ctl;
      logic        ret;
      logic [31:0] cnt;
   } exp_t;
   exp_t q[$];
   logic clk = 1'b0;
   logic rst0, rdy0, rst1, rdy1;
   logic [6:0] op0, op1;
   logic [2:0] f30, f31;
   wire [18:0] ctl0, ctl1;
   wire ret0, ret1;
   wire [31:0] cnt0;
   wire [3:0] cnt1, st0, st1;
   logic [31:0] ec0 = 0;
   logic [3:0] ec1 = 0;
   int tests = 0, fails = 0;
   always #5 clk = ~clk;
   multicycle_control_unit u0 (
      .clk_i(clk), .rst_n_i(rst0), .opcode_i(op0), .funct_3_i(f30), .mem_ready_i(rdy0),
      .pc_wr_en_o(ctl0[18]), .adr_src_o(ctl0[17]), .ir_wr_en_o(ctl0[16]), .mem_rd_en_o(ctl0[15]),
      .mem_wr_en_o(ctl0[14]), .reg_wr_en_o(ctl0[13]), .imm_src_o(ctl0[12:10]), .alu_src_a_o(ctl0[9:8]),
      .alu_src_b_o(ctl0[7:6]), .result_src_o(ctl0[5:4]), .alu_op_o(ctl0[3:2]), .branch_o(ctl0[1]),
      .illegal_instr_o(ctl0[0]), .retire_o(ret0), .instr_count_o(cnt0), .state_o(st0)
   );
   multicycle_control_unit #(.MEM_HANDSHAKE(1'b0), .ILLEGAL_HALT(1'b0), .CNT_W(4)) u1 (
      .clk_i(clk), .rst_n_i(rst1), .opcode_i(op1), .funct_3_i(f31), .mem_ready_i(rdy1),
      .pc_wr_en_o(ctl1[18]), .adr_src_o(ctl1[17]), .ir_wr_en_o(ctl1[16]), .mem_rd_en_o(ctl1[15]),
      .mem_wr_en_o(ctl1[14]), .reg_wr_en_o(ctl1[13]), .imm_src_o(ctl1[12:10]), .alu_src_a_o(ctl1[9:8]),
      .alu_src_b_o(ctl1[7:6]), .result_src_o(ctl1[5:4]), .alu_op_o(ctl1[3:2]), .branch_o(ctl1[1]),
      .illegal_instr_o(ctl1[0]), .retire_o(ret1), .instr_count_o(cnt1), .state_o(st1)
   );
   task automatic step(input logic id, input logic [3:0] st, input logic [18:0] ctl, input logic ret);
      q.push_back('{id, st, ctl, ret, id ? {28'b0, ec1} : ec0});
      @(posedge clk);
      #1;
      if (ret && id) ec1 = ec1 + 4'd1;
      if (ret && !id) ec0 = ec0 + 32'd1;
   endtask
   // monitor: pops one expected cycle per falling edge and compares against the selected unit
   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         logic [3:0] ast;
         logic [18:0] actl;
         logic aret;
         logic [31:0] acnt;
         e = q.pop_front();
         ast  = e.id ? st1 : st0;
         actl = e.id ? ctl1 : ctl0;
         aret = e.id ? ret1 : ret0;
         acnt = e.id ? {28'b0, cnt1} : cnt0;
         tests += 4;
         if (ast !== e.st) begin fails++; $display("FAIL state u%0d t=%0t got %0d want %0d", e.id, $time, ast, e.st); end
         if (actl !== e.ctl) begin fails++; $display("FAIL ctl u%0d t=%0t st=%0d got %b want %b", e.id, $time, e.st, actl, e.ctl); end
         if (aret !== e.ret) begin fails++; $display("FAIL retire u%0d t=%0t st=%0d got %b want %b", e.id, $time, e.st, aret, e.ret); end
         if (acnt !== e.cnt) begin fails++; $display("FAIL count u%0d t=%0t got %0d want %0d", e.id, $time, acnt, e.cnt); end
      end
   end
   initial begin
      rst0 = 1'b0; rst1 = 1'b0; rdy0 = 1'b0; rdy1 = 1'b0;
      op0 = 7'b0110011; op1 = 7'b1111111; f30 = 3'b000; f31 = 3'b000;
      @(posedge clk);
      #1;
      step(0, S_FETCH, C_FW, 0);
      rst0 = 1'b1; rdy0 = 1'b1;
      step(0, S_FETCH, C_F, 0);
      step(0, S_DECODE, C_DB, 0);
      step(0, S_EXEC_R, C_XR, 0);
      step(0, S_ALU_WB, C_AW, 1);
      op0 = 7'b0000011;
      step(0, S_FETCH, C_F, 0);
      step(0, S_DECODE, C_DB, 0);
      step(0, S_MEM_ADR, C_AL, 0);
      rdy0 = 1'b0;
      for (int i = 0; i < 3; i++) step(0, S_MEM_READ, C_RD, 0);
      rdy0 = 1'b1;
      step(0, S_MEM_READ, C_RD, 0);
      step(0, S_MEM_WB, C_MWB, 1);
      op0 = 7'b0010011; f30 = 3'b101;
      step(0, S_FETCH, C_F, 0);
      step(0, S_DECODE, C_DB, 0);
      step(0, S_EXEC_I, C_XS, 0);
      step(0, S_ALU_WB, C_AW, 1);
      f30 = 3'b000;
      step(0, S_FETCH, C_F, 0);
      step(0, S_DECODE, C_DB, 0);
      step(0, S_EXEC_I, C_XI, 0);
      step(0, S_ALU_WB, C_AW, 1);
      op0 = 7'b1100011;
      step(0, S_FETCH, C_F, 0);
      step(0, S_DECODE, C_DB, 0);
      step(0, S_BRANCH, C_BR, 1);
      op0 = 7'b1101111;
      step(0, S_FETCH, C_F, 0);
      step(0, S_DECODE, C_DJ, 0);
      step(0, S_JAL, C_JL, 0);
      step(0, S_ALU_WB, C_AW, 1);
      op0 = 7'b1100111;
      step(0, S_FETCH, C_F, 0);
      step(0, S_DECODE, C_DB, 0);
      step(0, S_JALR, C_JR, 0);
      step(0, S_JALR_LINK, C_LK, 0);
      step(0, S_ALU_WB, C_AW, 1);
      op0 = 7'b0110111;
      step(0, S_FETCH, C_F, 0);
      step(0, S_DECODE, C_DB, 0);
      step(0, S_LUI, C_LU, 0);
      step(0, S_ALU_WB, C_AW, 1);
      op0 = 7'b0010111;
      step(0, S_FETCH, C_F, 0);
      step(0, S_DECODE, C_DB, 0);
      step(0, S_AUIPC, C_AU, 0);
      step(0, S_ALU_WB, C_AW, 1);
      op0 = 7'b0100011; rdy0 = 1'b0;
      step(0, S_FETCH, C_FW, 0);
      rdy0 = 1'b1;
      step(0, S_FETCH, C_F, 0);
      step(0, S_DECODE, C_DB, 0);
      step(0, S_MEM_ADR, C_AS, 0);
      rdy0 = 1'b0;
      step(0, S_MEM_WRITE, C_WR, 0);
      rdy0 = 1'b1;
      step(0, S_MEM_WRITE, C_WR, 1);
      op0 = 7'b1111111;
      step(0, S_FETCH, C_F, 0);
      step(0, S_DECODE, C_DB, 0);
      for (int i = 0; i < 3; i++) step(0, S_ILLEGAL, C_IL, 0);
      rst0 = 1'b0; rdy0 = 1'b0; ec0 = 0;
      step(0, S_FETCH, C_FW, 0);
      rst0 = 1'b1; rdy0 = 1'b1; op0 = 7'b0100011;
      step(0, S_FETCH, C_F, 0);
      step(0, S_DECODE, C_DB, 0);
      step(0, S_MEM_ADR, C_AS, 0);
      rdy0 = 1'b0;
      step(0, S_MEM_WRITE, C_WR, 0);
      #1;
      rst0 = 1'b0; ec0 = 0;
      step(0, S_FETCH, C_FW, 0);
      rst1 = 1'b1;
      step(1, S_FETCH, C_F, 0);
      step(1, S_DECODE, C_DB, 0);
      step(1, S_ILLEGAL, C_IL, 0);
      op1 = 7'b1100011;
      for (int i = 0; i < 16; i++) begin
         step(1, S_FETCH, C_F, 0);
         step(1, S_DECODE, C_DB, 0);
         step(1, S_BRANCH, C_BR, 1);
      end
      step(1, S_FETCH, C_F, 0);
      @(negedge clk);
      #1;
      tests++;
      if (q.size() != 0) begin fails++; $display("FAIL drain left %0d entries want 0", q.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL timeout reached");
      $fatal(1, "timeout");
   end
endmodule
